mem_responder: RTL and testbench

- Memory-side responder for the Mini SRC datapath's Read/Write strobes.
- Latches the address from MAR and the write data from MDR, then performs the access on an internal word-addressed RAM after a programmable number of wait states.
- Returns read data for MDR and signals completion with a four-phase done handshake, so the control unit can stall in a wait state until the access finishes.

---
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the Mini SRC Read/Write strobes: latches MAR/MDR,
// performs the access after WAIT_CYCLES wait states, and completes with a four-phase done handshake.
module mem_responder #(
  parameter int    ADDR_WIDTH  = 9,
  parameter int    DATA_WIDTH  = 32,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_is_wr;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

  logic w_req_any, w_req_one, w_oor, w_accept, w_reject, w_fire, w_mem_we;

  assign w_req_any = Read | Write;
  assign w_req_one = Read ^ Write;
  assign w_oor     = |addr[31:ADDR_WIDTH];
  assign w_accept  = (r_state == S_IDLE) && w_req_one && !w_oor;
  assign w_reject  = (r_state == S_IDLE) && w_req_any && !w_accept;
  assign w_fire    = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  // The write edge only exists while in ACCESS, so an async reset beforehand cancels it.
  assign w_mem_we  = w_fire && r_is_wr;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
                else if (w_reject) w_state_nxt = S_DONE;
      S_ACCESS: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      S_DONE:   if (!w_req_any) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata_nxt = r_rdata;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    if (w_reject) begin
      w_rdata_nxt = '0;
      w_done_nxt  = 1'b1;
      w_err_nxt   = 1'b1;
    end else if (w_fire) begin
      if (!r_is_wr) w_rdata_nxt = r_mem[r_addr];
      w_done_nxt = 1'b1;
      w_err_nxt  = 1'b0;
    end else if ((r_state == S_DONE) && !w_req_any) begin
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
    end
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= CNT_INIT;
      r_addr  <= addr[ADDR_WIDTH-1:0];
      r_wdata <= wdata;
      r_is_wr <= Write;
    end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_wdata;
  end

  assign rdata = r_rdata;
  assign done  = r_done;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a default (2 wait-state) and a zero-wait instance
// are checked against a word-array model with latency derived from the handshake rules.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] a2, a0, d2, d0;
  logic [31:0] rdata2, rdata0;
  logic        done2, busy2, err2, done0, busy0, err0;

  always #5 clk = ~clk;

  mem_responder u_dut (
    .clk(clk), .reset(reset), .Read(rd2), .Write(wr2), .addr(a2), .wdata(d2),
    .rdata(rdata2), .done(done2), .busy(busy2), .err(err2)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .Read(rd0), .Write(wr0), .addr(a0), .wdata(d0),
    .rdata(rdata0), .done(done0), .busy(busy0), .err(err0)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem2 [int];
  logic [31:0] mem0 [int];
  int          wq2 [$];
  int          wq0 [$];
  logic [31:0] exp_rd2 = '0;
  logic [31:0] exp_rd0 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic        o_done (input bit z); return z ? done0  : done2;  endfunction
  function automatic logic        o_busy (input bit z); return z ? busy0  : busy2;  endfunction
  function automatic logic        o_err  (input bit z); return z ? err0   : err2;   endfunction
  function automatic logic [31:0] o_rdata(input bit z); return z ? rdata0 : rdata2; endfunction

  task automatic drive(input bit z, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (z) begin rd0 = r; wr0 = w; a0 = a; d0 = d; end
    else   begin rd2 = r; wr2 = w; a2 = a; d2 = d; end
  endtask

  // One full four-phase transaction; 'hold' extra cycles with the request still high.
  task automatic xact(input bit z, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int hold, input string tag);
    int          lat;
    int          exp_lat;
    bit          bad;
    logic [31:0] exp_rd;
    bad     = (r && w) || (a >= 32'd512);
    exp_lat = bad ? 1 : (z ? 0 : 2) + 2;
    exp_rd  = z ? exp_rd0 : exp_rd2;
    if (bad)    exp_rd = '0;
    else if (r) exp_rd = z ? mem0[int'(a)] : mem2[int'(a)];
    drive(z, r, w, a, d);
    lat = 0;
    while (!o_done(z) && lat < 50) begin
      tick;
      lat++;
    end
    chk({tag, ":lat"},   lat,        exp_lat);
    chk({tag, ":rdata"}, o_rdata(z), exp_rd);
    chk({tag, ":err"},   o_err(z),   bad);
    chk({tag, ":busy"},  o_busy(z),  1'b1);
    for (int i = 0; i < hold; i++) begin
      drive(z, r, w, a ^ 32'd1, ~d);
      tick;
      chk({tag, ":hold_done"},  o_done(z),  1'b1);
      chk({tag, ":hold_rdata"}, o_rdata(z), exp_rd);
    end
    drive(z, 1'b0, 1'b0, $urandom, $urandom);
    tick;
    chk({tag, ":rel_done"},  o_done(z),  1'b0);
    chk({tag, ":rel_busy"},  o_busy(z),  1'b0);
    chk({tag, ":rel_err"},   o_err(z),   1'b0);
    chk({tag, ":rel_rdata"}, o_rdata(z), exp_rd);
    if (!bad && w) begin
      if (z) begin mem0[int'(a)] = d; wq0.push_back(int'(a)); end
      else   begin mem2[int'(a)] = d; wq2.push_back(int'(a)); end
    end
    if (z) exp_rd0 = exp_rd; else exp_rd2 = exp_rd;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst:done", done2, 1'b0);
    chk("rst:busy", busy2, 1'b0);
    chk("rst:err",  err2,  1'b0);
    chk("rst:rdata", rdata2, 32'h0);
    chk("rst:busy0", busy0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick;

    // Write then read, and hold the read to exercise the four-phase wait
    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "wr10");
    xact(0, 1'b0, 1'b1, 32'h11, 32'h01010101, 0, "wr11");
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, "rd10");
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0, 5, "4ph");

    // Rejections leave RAM untouched
    xact(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 0, "wr20");
    xact(0, 1'b0, 1'b1, 32'h00, 32'h13579BDF, 0, "wr00");
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, "rd20a");
    xact(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 0, "rej_rw");
    xact(0, 1'b0, 1'b1, 32'h200, 32'h12345678, 0, "rej_oor");
    xact(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, "rd20b");
    xact(0, 1'b1, 1'b0, 32'h00, 32'h0, 0, "rd00");

    // Reset while the write is one wait state from committing
    xact(0, 1'b0, 1'b1, 32'h30, 32'h11111111, 0, "wr30");
    xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 0, "rd30a");
    drive(0, 1'b0, 1'b1, 32'h30, 32'hAAAA5555);
    tick;
    tick;
    chk("rst_mid:pre_busy", busy2, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid:done",  done2,  1'b0);
    chk("rst_mid:busy",  busy2,  1'b0);
    chk("rst_mid:err",   err2,   1'b0);
    chk("rst_mid:rdata", rdata2, 32'h0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    exp_rd2 = '0;
    exp_rd0 = '0;
    tick;
    xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 0, "rd30b");

    // Inputs change and the request drops while the read is in flight
    xact(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 0, "wr40");
    xact(0, 1'b0, 1'b1, 32'h41, 32'h55555555, 0, "wr41");
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick;
    drive(0, 1'b0, 1'b0, 32'h41, 32'hFFFFFFFF);
    lat = 1;
    while (!done2 && lat < 50) begin
      tick;
      lat++;
    end
    chk("drop:lat",   lat,    4);
    chk("drop:rdata", rdata2, 32'hCAFEF00D);
    tick;
    chk("drop:pulse", done2,  1'b0);
    chk("drop:busy",  busy2,  1'b0);
    exp_rd2 = 32'hCAFEF00D;

    // Zero wait-state instance at the top word
    xact(1, 1'b0, 1'b1, 32'h1FF, 32'h0000ABCD, 0, "w0_wr");
    xact(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 0, "w0_rd");
    xact(1, 1'b0, 1'b1, 32'h200, 32'h0, 0, "w0_oor");

    for (int i = 0; i < 80; i++) begin
      bit          z;
      int          kind;
      int          hold;
      logic [31:0] a;
      z    = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 9);
      hold = $urandom_range(0, 3);
      if (kind < 4) begin
        xact(z, 1'b0, 1'b1, 32'($urandom_range(0, 511)), $urandom, hold, "rnd_wr");
      end else if (kind < 8) begin
        if (z) a = 32'(wq0[$urandom_range(0, wq0.size() - 1)]);
        else   a = 32'(wq2[$urandom_range(0, wq2.size() - 1)]);
        xact(z, 1'b1, 1'b0, a, $urandom, hold, "rnd_rd");
      end else if (kind == 8) begin
        xact(z, 1'b1, 1'b1, 32'($urandom_range(0, 511)), $urandom, hold, "rnd_rw");
      end else begin
        a = $urandom | 32'h0000_0200;
        xact(z, $urandom_range(0, 1) == 1, 1'b1, a, $urandom, hold, "rnd_oor");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
